ula_muldiv_ctl: RTL and testbench



---
 rtl/ula_muldiv_ctl.sv | 171 +++++++++++++++++
 tb/tb_ula_muldiv_ctl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/ula_muldiv_ctl.sv
// ula_muldiv_ctl
// Multi-cycle unsigned multiply / divide / remainder unit that sits beside
// the combinational ULA. One operation is accepted per start handshake and
// one shift-add (mul) or restoring-subtract (div/rem) step runs per clock.
//
// State table:
//   IDLE | waiting for start; operands and op are sampled here
//   CALC | iterating, one step per edge, busy = 1
//   DONE | one-cycle done pulse, result and div_zero valid
//
// Ports:
//   clock     system clock, rising edge
//   reset     asynchronous, active-high reset
//   start     request, sampled only in IDLE
//   op        00 = mul, 01 = div, 10 = rem, 11 = reserved
//   A         multiplicand / dividend
//   B         multiplier / divisor
//   busy      high while in CALC
//   done      one-cycle completion pulse
//   result    registered result, held until the next completion
//   zero      result == 0
//   div_zero  set on completion of div/rem with B == 0
module ula_muldiv_ctl #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_REM = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd;  // multiplicand (mul) or divisor (div/rem)
  // {hi, lo} is the working pair:
  //   mul     : hi = upper product half, lo = multiplier shifting out / low product
  //   div/rem : hi = partial remainder,  lo = dividend shifting out / quotient
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] hi_nxt;
  logic [WIDTH-1:0] lo_nxt;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
    div_trial = {hi, lo[WIDTH-1]};
    // Only used when div_trial >= opnd, so the difference fits in WIDTH bits.
    div_diff  = div_trial[WIDTH-1:0] - opnd;
    hi_nxt    = hi;
    lo_nxt    = lo;
    if (op_q == OP_MUL) begin
      // Add-then-shift-right of the whole 2*WIDTH accumulator, carry included.
      hi_nxt = mul_sum[WIDTH:1];
      lo_nxt = {mul_sum[0], lo[WIDTH-1:1]};
    end else if (div_trial >= {1'b0, opnd}) begin
      hi_nxt = div_diff;
      lo_nxt = {lo[WIDTH-2:0], 1'b1};
    end else begin
      hi_nxt = div_trial[WIDTH-1:0];
      lo_nxt = {lo[WIDTH-2:0], 1'b0};
    end
  end

  assign zero = (result == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      op_q     <= '0;
      cnt      <= '0;
      opnd     <= '0;
      hi       <= '0;
      lo       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
      div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            case (op)
              OP_MUL: begin
                op_q  <= op;
                opnd  <= A;
                hi    <= '0;
                lo    <= B;
                cnt   <= '0;
                busy  <= 1'b1;
                state <= CALC;
              end
              OP_DIV, OP_REM: begin
                if (B == '0) begin
                  // Divide by zero short-cuts straight to DONE.
                  result   <= (op == OP_DIV) ? '1 : A;
                  div_zero <= 1'b1;
                  done     <= 1'b1;
                  state    <= DONE;
                end else begin
                  op_q  <= op;
                  opnd  <= B;
                  hi    <= '0;
                  lo    <= A;
                  cnt   <= '0;
                  busy  <= 1'b1;
                  state <= CALC;
                end
              end
              default: begin
                result   <= '0;
                div_zero <= 1'b0;
                done     <= 1'b1;
                state    <= DONE;
              end
            endcase
          end
        end

        CALC: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            result   <= (op_q == OP_REM) ? hi_nxt : lo_nxt;
            div_zero <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b1;
            state    <= DONE;
          end
        end

        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ula_muldiv_ctl.sv
module tb_ula_muldiv_ctl;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        div_zero;
  logic        clk_en;

  int checks = 0;
  int errors = 0;

  ula_muldiv_ctl #(.WIDTH(32)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .op       (op),
    .A        (A),
    .B        (B),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .div_zero (div_zero)
  );

  initial begin
    clock = 1'b0;
    forever begin
      #5;
      if (clk_en) clock = ~clock;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        dz;
    int          lat;
    bit          inject;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: {div_zero, result} from plain arithmetic.
  function automatic logic [32:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (o)
      2'b00: begin
        p = 64'(a) * 64'(b);
        return {1'b0, p[31:0]};
      end
      2'b01: return (b == 0) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, a / b};
      2'b10: return (b == 0) ? {1'b1, a} : {1'b0, a % b};
      default: return 33'd0;
    endcase
  endfunction

  function automatic int model_lat(input logic [1:0] o, input logic [31:0] b);
    if (o == 2'b11) return 1;
    if (o != 2'b00 && b == 0) return 1;
    return 33;
  endfunction

  // Called #1 after a rising edge with the DUT in IDLE. Latency counts the
  // start-sampling edge as edge 1.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic edz, input int elat,
                        input bit inject, input string tag);
    int          n;
    logic        stable;
    logic        busy_ok;
    logic [31:0] held;
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clock); #1;
    start = 1'b0; A = $urandom; B = $urandom; op = 2'($urandom);
    held = result; stable = 1'b1; busy_ok = 1'b1; n = 1;
    while (!done && n < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (inject && (n == 5 || n == 20)) begin
        start = 1'b1; op = 2'b00; A = $urandom; B = $urandom;
      end else begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      n++;
      if (!done && result !== held) stable = 1'b0;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(n), 64'(elat));
    chk({tag, " result"}, 64'(result), 64'(er));
    chk({tag, " div_zero"}, 64'(div_zero), 64'(edz));
    chk({tag, " zero"}, 64'(zero), 64'(er == 0));
    chk({tag, " busy_in_done"}, 64'(busy), 64'd0);
    if (elat > 1) begin
      chk({tag, " busy_during_calc"}, 64'(busy_ok), 64'd1);
      chk({tag, " result_stable"}, 64'(stable), 64'd1);
    end
    // start during the DONE cycle must be ignored
    start = 1'b1; op = inject ? 2'b00 : 2'b11; A = $urandom; B = $urandom;
    @(posedge clock); #1;
    start = 1'b0;
    chk({tag, " done_one_cycle"}, 64'(done), 64'd0);
    chk({tag, " start_in_done_ignored"}, 64'(busy), 64'd0);
    chk({tag, " result_held"}, 64'(result), 64'(er));
  endtask

  initial begin
    logic [32:0] m;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    bit          saw_done;

    vecs[0]  = '{2'b00, 32'd7,          32'd6,          32'd42,         1'b0, 33, 1'b1};
    vecs[1]  = '{2'b00, 32'h0001_0000,  32'h0001_0000,  32'd0,          1'b0, 33, 1'b0};
    vecs[2]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0, 33, 1'b0};
    vecs[3]  = '{2'b10, 32'd100,        32'd7,          32'd2,          1'b0, 33, 1'b0};
    vecs[4]  = '{2'b01, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  1'b0, 33, 1'b0};
    vecs[5]  = '{2'b01, 32'd5,          32'd0,          32'hFFFF_FFFF,  1'b1, 1,  1'b0};
    vecs[6]  = '{2'b10, 32'd5,          32'd0,          32'd5,          1'b1, 1,  1'b0};
    vecs[7]  = '{2'b01, 32'd100,        32'd7,          32'd14,         1'b0, 33, 1'b0};
    vecs[8]  = '{2'b11, 32'd9,          32'd3,          32'd0,          1'b0, 1,  1'b0};
    vecs[9]  = '{2'b01, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  1'b0, 33, 1'b0};
    vecs[10] = '{2'b10, 32'hDEAD_BEEF,  32'h10,         32'hF,          1'b0, 33, 1'b0};

    clk_en = 1'b0;
    reset  = 1'b0;
    start  = 1'b0;
    op     = 2'b00;
    A      = '0;
    B      = '0;

    // Asynchronous reset with the clock stopped
    #2 reset = 1'b1;
    #2;
    chk("reset result", 64'(result), 64'd0);
    chk("reset zero", 64'(zero), 64'd1);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset div_zero", 64'(div_zero), 64'd0);

    clk_en = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < NV; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].dz,
             vecs[i].lat, vecs[i].inject, $sformatf("vec%0d", i));

    // Reset in the middle of a div
    start = 1'b1; op = 2'b01; A = 32'd1000; B = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clock); #1;
    end
    chk("midop busy_before_reset", 64'(busy), 64'd1);
    #3 reset = 1'b1;
    #1;
    chk("midop busy", 64'(busy), 64'd0);
    chk("midop done", 64'(done), 64'd0);
    chk("midop result", 64'(result), 64'd0);
    chk("midop zero", 64'(zero), 64'd1);
    @(posedge clock); #1;
    reset = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) saw_done = 1'b1;
    end
    chk("midop no_done_after_abort", 64'(saw_done), 64'd0);
    run_op(2'b01, 32'd1000, 32'd3, 32'd333, 1'b0, 33, 1'b0, "after_reset");

    // Randomized operations against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      else if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 255));
      if ($urandom_range(0, 5) == 0) ra = 32'($urandom_range(0, 1000));
      m = model(ro, ra, rb);
      run_op(ro, ra, rb, m[31:0], m[32], model_lat(ro, rb),
             ($urandom_range(0, 3) == 0), $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
